// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and the address decoder for the mmio_memory block.
//   region_t    - which resource an address selects
//   decode_t    - region plus the word offset inside that region
//   mmio_decode - maps a CPU word address onto a region and offset, given the
//                 RAM and screen address widths and whether the timer exists
package mmio_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_TIMER,
        REG_NONE
    } region_t;

    typedef struct packed {
        region_t     region;
        logic [31:0] offset;
    } decode_t;

    // RAM sits at the bottom, the screen directly above it, then the keyboard
    // word and (optionally) the timer word. Anything else is unmapped.
    function automatic decode_t mmio_decode(input logic [31:0] addr,
                                            input int          ram_aw,
                                            input int          scr_aw,
                                            input logic        timer_en);
        logic [31:0] ram_top;
        logic [31:0] scr_top;
        decode_t     d;
        ram_top  = 32'd1 << ram_aw;
        scr_top  = ram_top + (32'd1 << scr_aw);
        d.region = REG_NONE;
        d.offset = 32'd0;
        if (addr < ram_top) begin
            d.region = REG_RAM;
            d.offset = addr;
        end else if (addr < scr_top) begin
            d.region = REG_SCREEN;
            d.offset = addr - ram_top;
        end else if (addr == scr_top) begin
            d.region = REG_KBD;
        end else if (timer_en && (addr == scr_top + 32'd1)) begin
            d.region = REG_TIMER;
        end
        return d;
    endfunction

endpackage

// File: rtl/mmio_dp_ram.sv
// mmio_dp_ram: 2^AW x WIDTH memory with one read/write port (A) and one
// read-only port (B). Both reads are synchronous.
//   clock, reset        - reset clears only the port B output register
//   we, a_addr, a_wdata - port A write
//   a_rdata             - port A read data, one cycle after a_addr
//   b_en, b_addr        - port B read enable/address; b_rdata holds when b_en=0
//   b_rdata             - port B read data, one cycle after b_addr
// Port B returns the old word when port A writes the same word in the same
// cycle (read-before-write).
module mmio_dp_ram #(
    parameter int WIDTH = 16,
    parameter int AW    = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_en,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] b_rdata
);

    logic [WIDTH-1:0] mem [0:(1 << AW)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[a_addr] <= a_wdata;
        end
        a_rdata <= mem[a_addr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            b_rdata <= '0;
        end else if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/mmio_memory.sv
// mmio_memory: CPU data space decoded into RAM, a dual-ported screen buffer,
// a latched keyboard register and an optional cycle timer, plus a free-running
// scan that streams the screen buffer to a display refresh port.
// Optional feature: define MMIO_TIMER_EN to add the cycle timer at SCR_TOP+1.
//   clock, reset       - single clock, synchronous active-high reset
//   in, load, address  - CPU write data, write enable, word address
//   out                - CPU read data, one cycle after address
//   key_code/key_strobe- keyboard code and its one-cycle valid pulse
//   key_pending        - a latched key has not been read yet
//   scan_en            - advance the display scan
//   scan_addr          - screen word being fetched
//   scan_data          - screen word at the previous scan_addr
//   scan_frame         - pulses with the last word of the frame
//   bus_error          - sticky flag for unmapped or illegal accesses
module mmio_memory
    import mmio_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15,
    parameter int RAM_AW = 14,
    parameter int SCR_AW = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out,
    input  logic [WIDTH-1:0]  key_code,
    input  logic              key_strobe,
    output logic              key_pending,
    input  logic              scan_en,
    output logic [SCR_AW-1:0] scan_addr,
    output logic [WIDTH-1:0]  scan_data,
    output logic              scan_frame,
    output logic              bus_error
);

`ifdef MMIO_TIMER_EN
    localparam logic TIMER_EN = 1'b1;
`else
    localparam logic TIMER_EN = 1'b0;
`endif

    // The map must leave room for the keyboard and timer words.
    if ((1 << RAM_AW) + (1 << SCR_AW) + 2 > (1 << ADDR_W)) begin : g_map_check
        $error("mmio_memory: RAM and screen do not fit in the address space");
    end

    decode_t dec;
    logic    offset_unused;
    assign dec           = mmio_decode(32'(address), RAM_AW, SCR_AW, TIMER_EN);
    assign offset_unused = ^dec.offset;

    logic is_ram, is_scr, is_kbd, is_tmr, is_none;
    assign is_ram  = (dec.region == REG_RAM);
    assign is_scr  = (dec.region == REG_SCREEN);
    assign is_kbd  = (dec.region == REG_KBD);
    assign is_tmr  = (dec.region == REG_TIMER);
    assign is_none = (dec.region == REG_NONE);

    logic             ram_we, scr_we;
    logic [WIDTH-1:0] ram_rdata, scr_rdata, ram_unused_b;
    assign ram_we = load && is_ram && !reset;
    assign scr_we = load && is_scr && !reset;

    mmio_dp_ram #(.WIDTH(WIDTH), .AW(RAM_AW)) u_ram (
        .clock   (clock),
        .reset   (reset),
        .we      (ram_we),
        .a_addr  (dec.offset[RAM_AW-1:0]),
        .a_wdata (in),
        .a_rdata (ram_rdata),
        .b_en    (1'b0),
        .b_addr  ('0),
        .b_rdata (ram_unused_b)
    );

    // Port B is the display scan; its output register is scan_data itself.
    mmio_dp_ram #(.WIDTH(WIDTH), .AW(SCR_AW)) u_screen (
        .clock   (clock),
        .reset   (reset),
        .we      (scr_we),
        .a_addr  (dec.offset[SCR_AW-1:0]),
        .a_wdata (in),
        .a_rdata (scr_rdata),
        .b_en    (scan_en),
        .b_addr  (scan_addr),
        .b_rdata (scan_data)
    );

`ifdef MMIO_TIMER_EN
    logic [WIDTH-1:0] timer_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + WIDTH'(1);
        end
    end
`endif

    // Non-memory read data is captured in the address cycle, so a keyboard
    // read that coincides with a strobe returns the old code.
    logic [WIDTH-1:0] key_code_q, misc_q, misc_d;
    always_comb begin
        misc_d = '0;
        if (is_kbd) begin
            misc_d = key_code_q;
        end
`ifdef MMIO_TIMER_EN
        else if (is_tmr) begin
            misc_d = timer_q;
        end
`endif
    end

    region_t region_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            region_q    <= REG_NONE;
            misc_q      <= '0;
            key_code_q  <= '0;
            key_pending <= 1'b0;
            bus_error   <= 1'b0;
            scan_addr   <= '0;
            scan_frame  <= 1'b0;
        end else begin
            region_q <= dec.region;
            misc_q   <= misc_d;
            if (key_strobe) begin
                key_code_q  <= key_code;
                key_pending <= 1'b1;
            end else if (is_kbd && !load) begin
                key_pending <= 1'b0;
            end
            if (is_none || (load && (is_kbd || is_tmr))) begin
                bus_error <= 1'b1;
            end
            if (scan_en) begin
                scan_addr  <= scan_addr + SCR_AW'(1);
                scan_frame <= &scan_addr;
            end else begin
                scan_frame <= 1'b0;
            end
        end
    end

    // Select between registered sources using the region of the last address.
    always_comb begin
        case (region_q)
            REG_RAM:    out = ram_rdata;
            REG_SCREEN: out = scr_rdata;
            default:    out = misc_q;
        endcase
    end

endmodule

// File: tb/tb_mmio_memory.sv
`timescale 1ns/1ps
module tb_mmio_memory;

    localparam int WIDTH   = 16;
    localparam int ADDR_W  = 15;
    localparam int RAM_AW  = 14;
    localparam int SCR_AW  = 13;
    localparam int RAM_TOP = 1 << RAM_AW;
    localparam int SCR_N   = 1 << SCR_AW;
    localparam int SCR_TOP = RAM_TOP + SCR_N;
`ifdef MMIO_TIMER_EN
    localparam bit HAS_TIMER = 1'b1;
`else
    localparam bit HAS_TIMER = 1'b0;
`endif

    localparam int R_RAM = 0, R_SCR = 1, R_KBD = 2, R_TMR = 3, R_NONE = 4;

    // ---------------- clock / reset / DUT ----------------
    logic              clock = 1'b0;
    logic              reset, load, key_strobe, scan_en;
    logic [WIDTH-1:0]  in, key_code;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  out, scan_data;
    logic [SCR_AW-1:0] scan_addr;
    logic              key_pending, scan_frame, bus_error;

    always #5 clock = ~clock;

    mmio_memory #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW), .SCR_AW(SCR_AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .in          (in),
        .load        (load),
        .address     (address),
        .out         (out),
        .key_code    (key_code),
        .key_strobe  (key_strobe),
        .key_pending (key_pending),
        .scan_en     (scan_en),
        .scan_addr   (scan_addr),
        .scan_data   (scan_data),
        .scan_frame  (scan_frame),
        .bus_error   (bus_error)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int frames   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] ram_m [int];
    logic [WIDTH-1:0] scr_m [int];
    logic [WIDTH-1:0] m_out, m_kcode, m_sdata, m_tmr;
    bit               m_out_k, m_sd_k, m_kpend, m_berr, m_frame;
    int               m_saddr;

    function automatic int region_of(input int a);
        if (a < RAM_TOP)                    return R_RAM;
        if (a < SCR_TOP)                    return R_SCR;
        if (a == SCR_TOP)                   return R_KBD;
        if (HAS_TIMER && (a == SCR_TOP + 1)) return R_TMR;
        return R_NONE;
    endfunction

    // Apply the current inputs for one clock edge, advance the model, check.
    task automatic tick();
        int               a, rg;
        logic [WIDTH-1:0] rd_v;
        bit               rd_k;
        a  = int'(address);
        rg = region_of(a);
        rd_v = '0;
        rd_k = 1'b1;
        if (reset) begin
            m_kcode = '0; m_kpend = 0; m_berr = 0;
            m_saddr = 0;  m_sdata = '0; m_sd_k = 1; m_frame = 0;
            m_tmr   = '0;
        end else begin
            case (rg)
                R_RAM: if (load || !ram_m.exists(a)) rd_k = 0; else rd_v = ram_m[a];
                R_SCR: if (load || !scr_m.exists(a - RAM_TOP)) rd_k = 0; else rd_v = scr_m[a - RAM_TOP];
                R_KBD: rd_v = m_kcode;
                R_TMR: rd_v = m_tmr;
                default: rd_v = '0;
            endcase
            // Scan reads the old contents before this cycle's CPU write lands.
            if (scan_en) begin
                m_sd_k = scr_m.exists(m_saddr);
                if (m_sd_k) m_sdata = scr_m[m_saddr];
                m_frame = (m_saddr == SCR_N - 1);
                m_saddr = (m_saddr + 1) % SCR_N;
            end else begin
                m_frame = 0;
            end
            if (load && rg == R_RAM) ram_m[a] = in;
            if (load && rg == R_SCR) scr_m[a - RAM_TOP] = in;
            if (key_strobe) begin
                m_kcode = key_code;
                m_kpend = 1;
            end else if (rg == R_KBD && !load) begin
                m_kpend = 0;
            end
            if (rg == R_NONE || (load && (rg == R_KBD || rg == R_TMR))) m_berr = 1;
            m_tmr = m_tmr + 16'd1;
        end
        m_out   = rd_v;
        m_out_k = rd_k;
        @(posedge clock);
        #1;
        if (m_out_k) check("out", 32'(out), 32'(m_out));
        check("key_pending", 32'(key_pending), 32'(m_kpend));
        check("bus_error", 32'(bus_error), 32'(m_berr));
        check("scan_addr", 32'(scan_addr), 32'(m_saddr));
        if (m_sd_k) check("scan_data", 32'(scan_data), 32'(m_sdata));
        check("scan_frame", 32'(scan_frame), 32'(m_frame));
        if (scan_frame) frames++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic ld, input int a, input logic [WIDTH-1:0] d);
        load    = ld;
        address = ADDR_W'(a);
        in      = d;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 0, '0);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] t0, t1;

    initial begin
        reset = 1'b1; load = 1'b0; address = '0; in = '0;
        key_code = '0; key_strobe = 1'b0; scan_en = 1'b0;
        m_sd_k = 1; m_out_k = 0; m_saddr = 0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out", 32'(out), 32'd0);
        check("rst_scan_addr", 32'(scan_addr), 32'd0);

        // Fill the screen so every scanned word is known; word 0 = 0xAAAA.
        for (int i = 0; i < SCR_N; i++) begin
            cyc(1'b1, RAM_TOP + i, (i == 0) ? 16'hAAAA : 16'($urandom));
        end

        // RAM write then read, including the top RAM word.
        cyc(1'b1, 5, 16'h1234);
        cyc(1'b0, 5, '0);
        check("ram5", 32'(out), 32'h1234);
        cyc(1'b1, RAM_TOP - 1, 16'hBEEF);
        cyc(1'b0, RAM_TOP - 1, '0);
        check("ram_top", 32'(out), 32'hBEEF);
        check("ram_top_berr", 32'(bus_error), 32'd0);

        // Full scan from reset: 2^SCR_AW + 1 cycles.
        do_reset();
        scan_en = 1'b1;
        frames  = 0;
        cyc(1'b0, 0, '0);
        check("scan_first_data", 32'(scan_data), 32'hAAAA);
        check("scan_first_addr", 32'(scan_addr), 32'd1);
        for (int i = 1; i < SCR_N + 1; i++) cyc(1'b0, 0, '0);
        check("scan_frames", 32'(frames), 32'd1);
        scan_en = 1'b0;

        // Keyboard latch, read-clear, and strobe colliding with a read.
        key_code = 16'h0041; key_strobe = 1'b1;
        cyc(1'b0, 0, '0);
        key_strobe = 1'b0;
        check("kbd_pending_set", 32'(key_pending), 32'd1);
        cyc(1'b0, SCR_TOP, '0);
        check("kbd_read", 32'(out), 32'h0041);
        check("kbd_pending_clr", 32'(key_pending), 32'd0);
        key_code = 16'h0042; key_strobe = 1'b1;
        cyc(1'b0, SCR_TOP, '0);
        key_strobe = 1'b0;
        check("kbd_collide_out", 32'(out), 32'h0041);
        check("kbd_collide_pend", 32'(key_pending), 32'd1);
        cyc(1'b1, SCR_TOP, 16'h5555);
        check("kbd_write_berr", 32'(bus_error), 32'd1);
        cyc(1'b0, SCR_TOP, '0);
        check("kbd_after_write", 32'(out), 32'h0042);

        // Unmapped read, sticky until reset.
        do_reset();
        cyc(1'b0, 16'h7000, '0);
        check("unmapped_out", 32'(out), 32'd0);
        check("unmapped_berr", 32'(bus_error), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 5, '0);
        do_reset();
        check("berr_cleared", 32'(bus_error), 32'd0);

        // Timer word.
`ifdef MMIO_TIMER_EN
        cyc(1'b0, SCR_TOP + 1, '0);
        t0 = out;
        for (int i = 0; i < 9; i++) cyc(1'b0, 5, '0);
        cyc(1'b0, SCR_TOP + 1, '0);
        t1 = out;
        check("timer_delta", 32'(t1 - t0), 32'd10);
        check("timer_berr", 32'(bus_error), 32'd0);
`else
        cyc(1'b0, SCR_TOP + 1, '0);
        t0 = out;
        t1 = '0;
        check("timer_off_out", 32'(t0), 32'(t1));
        check("timer_off_berr", 32'(bus_error), 32'd1);
`endif

        // Reset mid-frame at scan_addr=100.
        do_reset();
        scan_en = 1'b1;
        for (int i = 0; i < 100; i++) cyc(1'b0, 5, '0);
        check("scan_at_100", 32'(scan_addr), 32'd100);
        do_reset();
        check("scan_restart", 32'(scan_addr), 32'd0);
        check("scan_no_frame", 32'(scan_frame), 32'd0);
        scan_en = 1'b0;
        cyc(1'b0, 5, '0);
        check("ram_survives_reset", 32'(out), 32'h1234);

        // Randomized traffic across all regions.
        for (int i = 0; i < 3000; i++) begin
            int r, a;
            r = $urandom_range(0, 9);
            if (r < 2)      a = $urandom_range(0, 15);
            else if (r < 4) a = $urandom_range(RAM_TOP - 16, RAM_TOP - 1);
            else if (r < 7) a = $urandom_range(RAM_TOP, SCR_TOP - 1);
            else if (r == 7) a = SCR_TOP;
            else if (r == 8) a = SCR_TOP + 1;
            else            a = $urandom_range(SCR_TOP + 2, (1 << ADDR_W) - 1);
            reset      = ($urandom_range(0, 99) == 0);
            key_strobe = ($urandom_range(0, 7) == 0);
            key_code   = 16'($urandom);
            scan_en    = $urandom_range(0, 1) == 1;
            cyc($urandom_range(0, 2) == 0, a, 16'($urandom));
        end
        reset = 1'b0; key_strobe = 1'b0; scan_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
